bus_rsp: RTL and testbench

Memory-mapped responder endpoint for the main bus fabric. It answers word-sized read and write transactions that fall inside a configurable address window. Accesses are served from an internal register bank after a fixed, parameterised wait-state count, and each completion is signalled with a one-cycle acknowledge. It sits behind `busctl` as the target side of the processor-core bus protocol: the core initiates, this block responds.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_rsp_regfile.sv | 43 ++++
 rtl/bus_rsp.sv | 195 +++++++++++++++++++
 tb/tb_bus_rsp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the processor-core bus target blocks.
//   bus_rsp_state_t : responder FSM states (IDLE, WAIT, ACK)
//   BUS_AD_LEN      : default address width
//   BUS_DATA_W      : default data width
//   BUS_ERR_DATA    : all-ones read data returned on an error completion;
//                     64 bits wide so any data width up to 64 can be cut from it
// No ports (package).
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_AD_LEN = 32;
    localparam int BUS_DATA_W = 32;

    localparam logic [63:0] BUS_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_rsp_state_t;

endpackage

// File: rtl/bus_rsp_regfile.sv
// -----------------------------------------------------------------------------
// bus_rsp_regfile
// Word storage behind the bus responder: N_WORDS x BUS_WIDTH registers with a
// synchronous write port, a combinational read port and a synchronous clear.
// Ports:
//   i_clk    in  1          clock (rising edge)
//   i_rst    in  1          synchronous active-high clear of every word
//   i_we     in  1          write enable
//   i_widx   in  IDX_W      write word index
//   i_wdata  in  BUS_WIDTH  write data
//   i_ridx   in  IDX_W      read word index
//   o_rdata  out BUS_WIDTH  read data (combinational from i_ridx)
// -----------------------------------------------------------------------------
module bus_rsp_regfile #(
    parameter  int N_WORDS   = 16,
    parameter  int BUS_WIDTH = 32,
    localparam int IDX_W     = $clog2(N_WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_widx,
    input  logic [BUS_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]     i_ridx,
    output logic [BUS_WIDTH-1:0] o_rdata
);

    logic [BUS_WIDTH-1:0] r_mem [N_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // N_WORDS is a power of two, so every index value addresses a real word.
    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/bus_rsp.sv
// -----------------------------------------------------------------------------
// bus_rsp
// Memory-mapped responder for the processor-core bus. Answers word reads and
// writes inside [BASE, BASE + 4*N_WORDS) from an internal register bank after
// WAIT_CYCLES wait states, signalling each completion with a one-cycle ack.
// Optional feature macro: BUS_RSP_ERR_EN -- when defined, out-of-window
// accesses are completed with err_o = 1 and all-ones read data; when not
// defined, they are ignored and err_o does not exist.
// Ports:
//   clk_i    in  1          clock (rising edge)
//   reset_i  in  1          synchronous active-high reset
//   req_i    in  1          transaction request (level)
//   we_i     in  1          1 = write, 0 = read
//   ad_i     in  AD_LEN     byte address (bits [1:0] ignored)
//   wdata_i  in  BUS_WIDTH  write data
//   data_o   out BUS_WIDTH  read data, valid with ack_o, held otherwise
//   ack_o    out 1          completion strobe, one cycle
//   busy_o   out 1          transaction in flight (WAIT or ACK)
//   err_o    out 1          error completion (BUS_RSP_ERR_EN only)
// -----------------------------------------------------------------------------
module bus_rsp
    import bus_pkg::*;
#(
    parameter int                AD_LEN      = BUS_AD_LEN,
    parameter int                BUS_WIDTH   = BUS_DATA_W,
    parameter logic [AD_LEN-1:0] BASE        = 'h0000_1000,
    parameter int                N_WORDS     = 16,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AD_LEN-1:0]    ad_i,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 ack_o,
    output logic                 busy_o
`ifdef BUS_RSP_ERR_EN
   ,output logic                 err_o
`endif
);

    localparam int IDX_W = $clog2(N_WORDS);

    // One extra bit so an end address that would overflow AD_LEN is visible.
    localparam logic [AD_LEN:0] LP_END = {1'b0, BASE} + (AD_LEN+1)'(4 * N_WORDS);

    // Elaboration-time parameter checks.
    if (LP_END[AD_LEN]) begin : g_chk_end
        $error("bus_rsp: BASE + 4*N_WORDS overflows AD_LEN");
    end
    if (BASE[1:0] != 2'b00) begin : g_chk_align
        $error("bus_rsp: BASE must be 4-byte aligned");
    end
    if (N_WORDS < 2 || (N_WORDS & (N_WORDS - 1)) != 0) begin : g_chk_words
        $error("bus_rsp: N_WORDS must be a power of two, at least 2");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_chk_wait
        $error("bus_rsp: WAIT_CYCLES must be in 0..15");
    end

    bus_rsp_state_t       r_state;
    bus_rsp_state_t       w_next;
    logic [3:0]           r_cnt;
    logic                 r_we;
    logic                 r_miss;
    logic [IDX_W-1:0]     r_idx;
    logic [BUS_WIDTH-1:0] r_wdata;
    logic [BUS_WIDTH-1:0] r_data;
    logic                 r_ack;
    logic                 r_busy;
    logic                 r_err;

    logic                 w_hit;
    logic                 w_take;
    logic [AD_LEN-1:0]    w_off;
    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     w_ridx;
    logic                 w_rwe;
    logic                 w_rmiss;
    logic                 w_enter_ack;
    logic                 w_bank_we;
    logic [BUS_WIDTH-1:0] w_rdata;

    // Address decode. The subtraction is only meaningful on a hit, which is
    // the only case where its result is used, so it cannot wrap.
    assign w_hit = (ad_i >= BASE) && ({1'b0, ad_i} < LP_END);
    assign w_off = ad_i - BASE;
    assign w_idx = IDX_W'(w_off >> 2);

`ifdef BUS_RSP_ERR_EN
    // Misses are accepted and completed with an error.
    assign w_take = req_i;
`else
    // Misses are ignored; the fabric is left to time out.
    assign w_take = req_i & w_hit;
`endif

    // With WAIT_CYCLES = 0 the ACK state is entered straight from IDLE, so
    // the transaction attributes come from the live inputs rather than the
    // latched copies.
    assign w_ridx      = (r_state == IDLE) ? w_idx  : r_idx;
    assign w_rwe       = (r_state == IDLE) ? we_i   : r_we;
    assign w_rmiss     = (r_state == IDLE) ? ~w_hit : r_miss;
    assign w_enter_ack = (w_next == ACK) && (r_state != ACK);

    // Writes commit on the edge that leaves ACK; miss writes are dropped.
    assign w_bank_we = (r_state == ACK) && r_we && !r_miss;

    bus_rsp_regfile #(
        .N_WORDS   (N_WORDS),
        .BUS_WIDTH (BUS_WIDTH)
    ) u_regfile (
        .i_clk   (clk_i),
        .i_rst   (reset_i),
        .i_we    (w_bank_we),
        .i_widx  (r_idx),
        .i_wdata (r_wdata),
        .i_ridx  (w_ridx),
        .o_rdata (w_rdata)
    );

    // Next-state logic. The counter is loaded with WAIT_CYCLES on accept and
    // WAIT hands over to ACK on the edge where it counts down to zero.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_miss  <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == ACK);
            r_busy  <= (w_next != IDLE);
            r_err   <= (w_next == ACK) && w_rmiss;

            if (r_state == IDLE && w_take) begin
                r_we    <= we_i;
                r_miss  <= ~w_hit;
                r_idx   <= w_idx;
                r_wdata <= wdata_i;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // data_o only changes when entering ACK for a read or a miss;
            // hit writes leave the last read value in place.
            if (w_enter_ack) begin
                if (w_rmiss) begin
                    r_data <= BUS_WIDTH'(BUS_ERR_DATA);
                end else if (!w_rwe) begin
                    r_data <= w_rdata;
                end
            end
        end
    end

    assign data_o = r_data;
    assign ack_o  = r_ack;
    assign busy_o = r_busy;
`ifdef BUS_RSP_ERR_EN
    assign err_o  = r_err;
`endif

endmodule

// File: tb/tb_bus_rsp.sv
`timescale 1ns/1ps
// Bench for bus_rsp: instance 0 runs with WAIT_CYCLES = 2, instance 1 with
// WAIT_CYCLES = 0. A transaction-level model predicts busy/ack/data/err for
// every cycle from the accept edge number; directed reads pin literal values.
module tb_bus_rsp;

    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef BUS_RSP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        req  [2];
    logic        we   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] dout [2];
    logic        ack  [2];
    logic        busy [2];
`ifdef BUS_RSP_ERR_EN
    logic        err  [2];
`endif

    int checks = 0;
    int errors = 0;

    bus_rsp #(.AD_LEN(32), .BUS_WIDTH(32), .BASE(BASE), .N_WORDS(NW), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk_i   (clk),
        .reset_i (rst[0]),
        .req_i   (req[0]),
        .we_i    (we[0]),
        .ad_i    (ad[0]),
        .wdata_i (wd[0]),
        .data_o  (dout[0]),
        .ack_o   (ack[0]),
        .busy_o  (busy[0])
`ifdef BUS_RSP_ERR_EN
       ,.err_o   (err[0])
`endif
    );

    bus_rsp #(.AD_LEN(32), .BUS_WIDTH(32), .BASE(BASE), .N_WORDS(NW), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk_i   (clk),
        .reset_i (rst[1]),
        .req_i   (req[1]),
        .we_i    (we[1]),
        .ad_i    (ad[1]),
        .wdata_i (wd[1]),
        .data_o  (dout[1]),
        .ack_o   (ack[1]),
        .busy_o  (busy[1])
`ifdef BUS_RSP_ERR_EN
       ,.err_o   (err[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * NW));
    endfunction

    // ---------------- transaction-level model ----------------
    // A transaction accepted at edge A is busy for the cycles after edges
    // A..A+W, acks after edge A+W (read data appears then), commits its write
    // at edge A+W+1, and the next request can be accepted from edge A+W+2.
    int          edge_n = 0;
    bit          mvalid  [2];
    bit          pend    [2];
    int          acc     [2];
    int          free_at [2];
    bit          m_we    [2];
    bit          m_miss  [2];
    int          m_idx   [2];
    logic [31:0] m_wd    [2];
    logic [31:0] e_data  [2];
    logic [31:0] mem     [2][NW];

    always @(posedge clk) begin
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                mvalid[d]  = 1'b1;
                pend[d]    = 1'b0;
                free_at[d] = edge_n + 1;
                e_data[d]  = '0;
                for (int k = 0; k < NW; k++) mem[d][k] = '0;
            end else if (mvalid[d]) begin
                if (pend[d] && edge_n == acc[d] + wait_of(d) + 1) begin
                    if (m_we[d] && !m_miss[d]) mem[d][m_idx[d]] = m_wd[d];
                    pend[d] = 1'b0;
                end
                if (!pend[d] && edge_n >= free_at[d] && req[d] && (in_window(ad[d]) || ERR_EN)) begin
                    pend[d]    = 1'b1;
                    acc[d]     = edge_n;
                    m_we[d]    = we[d];
                    m_miss[d]  = !in_window(ad[d]);
                    m_idx[d]   = m_miss[d] ? 0 : int'((ad[d] - BASE) / 4);
                    m_wd[d]    = wd[d];
                    free_at[d] = edge_n + wait_of(d) + 2;
                end
                if (pend[d] && edge_n == acc[d] + wait_of(d)) begin
                    if (m_miss[d])   e_data[d] = 32'hFFFF_FFFF;
                    else if (!m_we[d]) e_data[d] = mem[d][m_idx[d]];
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mvalid[d]) begin
                logic e_busy, e_ack;
                e_busy = pend[d] && (edge_n - acc[d] <= wait_of(d));
                e_ack  = pend[d] && (edge_n == acc[d] + wait_of(d));
                chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(e_busy));
                chk($sformatf("ack%0d", d),  32'(ack[d]),  32'(e_ack));
                chk($sformatf("data%0d", d), dout[d], e_data[d]);
`ifdef BUS_RSP_ERR_EN
                chk($sformatf("err%0d", d),  32'(err[d]),  32'(e_ack && m_miss[d]));
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Runs one transaction, dropping req in the ACK cycle. Optionally
    // scrambles ad/wdata during the WAIT cycles.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                       input bit scramble, output logic [31:0] rd, output int lat, output int nbusy);
        int acc_e;
        bit got;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; ad[d] = a; wd[d] = data;
        @(negedge clk);
        acc_e = edge_n; got = 1'b0; nbusy = 0; rd = '0; lat = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (busy[d]) nbusy++;
            if (ack[d]) begin
                got = 1'b1; rd = dout[d]; lat = edge_n - acc_e; req[d] = 1'b0;
            end else if (scramble) begin
                ad[d] = BASE; wd[d] = 32'hDEAD_BEEF;
            end
        end
        if (!got) begin
            req[d] = 1'b0;
            chk("ack timeout", 32'd0, 32'd1);
        end
    endtask

    logic [31:0] rd;
    int          lat, nb;
    logic [31:0] vals [4];

    initial begin
        vals[0] = 32'h0123_4567; vals[1] = 32'h89AB_CDEF;
        vals[2] = 32'h5555_AAAA; vals[3] = 32'hF0F0_0F0F;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; ad[d] = '0; wd[d] = '0;
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Read of a cleared word: ack in the 3rd cycle after accept.
        txn(0, 1'b0, 32'h1000, '0, 1'b0, rd, lat, nb);
        chk("rd0 data", rd, 32'h0);
        chk("rd0 latency", 32'(lat), 32'd2);
        chk("rd0 busy cycles", 32'(nb), 32'd3);

        // Write then read with a byte offset.
        txn(0, 1'b1, 32'h1008, 32'hCAFE_F00D, 1'b0, rd, lat, nb);
        txn(0, 1'b0, 32'h100A, '0, 1'b0, rd, lat, nb);
        chk("rd 0x100A", rd, 32'hCAFE_F00D);

        // One past the window.
`ifdef BUS_RSP_ERR_EN
        txn(0, 1'b0, 32'h1040, '0, 1'b0, rd, lat, nb);
        chk("miss data", rd, 32'hFFFF_FFFF);
        chk("miss latency", 32'(lat), 32'd2);
`else
        begin
            int n_ack, n_busy;
            n_ack = 0; n_busy = 0;
            @(negedge clk);
            req[0] = 1'b1; we[0] = 1'b0; ad[0] = 32'h1040;
            repeat (6) begin
                @(negedge clk);
                if (ack[0])  n_ack++;
                if (busy[0]) n_busy++;
            end
            req[0] = 1'b0;
            chk("miss acks", 32'(n_ack), 32'd0);
            chk("miss busy", 32'(n_busy), 32'd0);
        end
`endif

        // Reset in the WAIT cycle of a write.
        txn(0, 1'b1, 32'h1004, 32'h1111_2222, 1'b0, rd, lat, nb);
        txn(0, 1'b0, 32'h1004, '0, 1'b0, rd, lat, nb);
        chk("rd 0x1004 pre", rd, 32'h1111_2222);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; ad[0] = 32'h1004; wd[0] = 32'h3333_4444;
        @(negedge clk);
        chk("abort busy", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("reset data_o", dout[0], 32'h0);
        txn(0, 1'b0, 32'h1004, '0, 1'b0, rd, lat, nb);
        chk("rd 0x1004 post", rd, 32'h0);
        txn(0, 1'b0, 32'h1008, '0, 1'b0, rd, lat, nb);
        chk("rd 0x1008 post", rd, 32'h0);

        // Inputs changed during WAIT must not affect the committed write.
        txn(0, 1'b1, 32'h100C, 32'hA5A5_5A5A, 1'b1, rd, lat, nb);
        txn(0, 1'b0, 32'h100C, '0, 1'b0, rd, lat, nb);
        chk("rd 0x100C", rd, 32'hA5A5_5A5A);
        txn(0, 1'b0, 32'h1000, '0, 1'b0, rd, lat, nb);
        chk("rd 0x1000 untouched", rd, 32'h0);

        // W = 0: four back-to-back writes with req held high.
        begin
            int n, last;
            n = 0; last = -1;
            @(negedge clk);
            req[1] = 1'b1; we[1] = 1'b1; ad[1] = BASE; wd[1] = vals[0];
            for (int k = 0; k < 40 && n < 4; k++) begin
                @(negedge clk);
                if (ack[1]) begin
                    if (n > 0) chk("b2b spacing", 32'(edge_n - last), 32'd2);
                    last = edge_n;
                    n++;
                    if (n < 4) begin
                        ad[1] = BASE + 32'(4 * n); wd[1] = vals[n];
                    end else begin
                        req[1] = 1'b0;
                    end
                end
            end
            chk("b2b count", 32'(n), 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b0, BASE + 32'(4 * i), '0, 1'b0, rd, lat, nb);
            chk($sformatf("w0 readback %0d", i), rd, vals[i]);
            chk("w0 latency", 32'(lat), 32'd0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
